// File: rtl/vga_scan_fetch.sv
// VGA scan controller: H/V timing, windowed framebuffer fetch with 2^SCALE_SHIFT replication, latency-matched syncs.
// Optional double buffering under `VGA_DBUF_EN` (adds iBufSel, widens oAddr by one bank bit).
module vga_scan_fetch #(
    parameter int SA          = 96,
    parameter int SB          = 48,
    parameter int SC          = 640,
    parameter int SD          = 16,
    parameter int SE          = 800,
    parameter int SO          = 2,
    parameter int SP          = 33,
    parameter int SQ          = 480,
    parameter int SR          = 10,
    parameter int SS          = 525,
    parameter int XSIZE       = 640,
    parameter int YSIZE       = 480,
    parameter int XOFF        = 0,
    parameter int YOFF        = 0,
    parameter int SCALE_SHIFT = 0,
    parameter int DW          = 9,
    parameter int AW          = 19,
    parameter int RD_LAT      = 1
) (
    input  logic          CLOCK,
    input  logic          RESET,
`ifdef VGA_DBUF_EN
    input  logic          iBufSel,
    output logic [AW:0]   oAddr,
`else
    output logic [AW-1:0] oAddr,
`endif
    output logic          oRdEn,
    input  logic [DW-1:0] iData,
    output logic [DW-1:0] VGAD,
    output logic          oHSYNC,
    output logic          oVSYNC,
    output logic          oFrameStart
);

    localparam int HW = $clog2(SE);
    localparam int VW = $clog2(SS);
    // Window is clipped to the active area so porch/sync never carries pixels.
    localparam int H_ACT_END = ((SA + SB + SC) < (SE - SD)) ? (SA + SB + SC) : (SE - SD);
    localparam int V_ACT_END = ((SO + SP + SQ) < (SS - SR)) ? (SO + SP + SQ) : (SS - SR);
    localparam int H_WIN_BEG = SA + SB + XOFF;
    localparam int V_WIN_BEG = SO + SP + YOFF;
    localparam int H_WIN_END = ((H_WIN_BEG + XSIZE) < H_ACT_END) ? (H_WIN_BEG + XSIZE) : H_ACT_END;
    localparam int V_WIN_END = ((V_WIN_BEG + YSIZE) < V_ACT_END) ? (V_WIN_BEG + YSIZE) : V_ACT_END;
    localparam logic [AW-1:0] ROW_STEP = AW'(XSIZE >> SCALE_SHIFT);
    localparam logic [2:0]    SUB_MAX  = 3'((1 << SCALE_SHIFT) - 1);

    logic [HW-1:0]     r_hcnt;
    logic [VW-1:0]     r_vcnt;
    logic [AW-1:0]     r_xsrc;
    logic [AW-1:0]     r_row_base;
    logic [2:0]        r_xsub;
    logic [2:0]        r_ysub;
    logic [31:0]       w_h32;
    logic [31:0]       w_v32;
    logic              w_h_zero;
    logic              w_v_zero;
    logic              w_h_last;
    logic              w_v_last;
    logic              w_in_x;
    logic              w_in_y;
    logic              w_win;
    logic [AW-1:0]     r_addr;
    logic              r_rden;
    logic              r_hs1;
    logic              r_vs1;
    logic [RD_LAT-1:0] r_win_d;
    logic [RD_LAT-1:0] r_hs_d;
    logic [RD_LAT-1:0] r_vs_d;
    logic [RD_LAT:0]   w_win_chain;
    logic [RD_LAT:0]   w_hs_chain;
    logic [RD_LAT:0]   w_vs_chain;
    logic [DW-1:0]     r_vgad;
    logic              r_hsync_n;
    logic              r_vsync_n;

    assign w_h32    = 32'(r_hcnt);
    assign w_v32    = 32'(r_vcnt);
    assign w_h_zero = (r_hcnt == HW'(0));
    assign w_v_zero = (r_vcnt == VW'(0));
    assign w_h_last = (r_hcnt == HW'(SE - 1));
    assign w_v_last = (r_vcnt == VW'(SS - 1));
    assign w_in_x   = (w_h32 >= 32'(H_WIN_BEG)) && (w_h32 < 32'(H_WIN_END));
    assign w_in_y   = (w_v32 >= 32'(V_WIN_BEG)) && (w_v32 < 32'(V_WIN_END));
    assign w_win    = w_in_x && w_in_y;

    // Free-running raster counters.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_h_last) begin
            r_hcnt <= '0;
            r_vcnt <= w_v_last ? '0 : (r_vcnt + VW'(1));
        end else begin
            r_hcnt <= r_hcnt + HW'(1);
        end
    end

    // Source column: advances once per 2^SCALE_SHIFT in-window pixels.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_xsrc <= '0;
            r_xsub <= 3'd0;
        end else if (w_h_zero) begin
            r_xsrc <= '0;
            r_xsub <= 3'd0;
        end else if (w_win) begin
            if (r_xsub == SUB_MAX) begin
                r_xsub <= 3'd0;
                r_xsrc <= r_xsrc + AW'(1);
            end else begin
                r_xsub <= r_xsub + 3'd1;
            end
        end
    end

    // Source row base: stepped by one source row every 2^SCALE_SHIFT window lines; frame clear wins.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_row_base <= '0;
            r_ysub     <= 3'd0;
        end else if (w_h_zero && w_v_zero) begin
            r_row_base <= '0;
            r_ysub     <= 3'd0;
        end else if (w_h_last && w_in_y) begin
            if (r_ysub == SUB_MAX) begin
                r_ysub     <= 3'd0;
                r_row_base <= r_row_base + ROW_STEP;
            end else begin
                r_ysub <= r_ysub + 3'd1;
            end
        end
    end

    // Stage 1: read request plus sync levels captured at the same raster position.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_addr <= '0;
            r_rden <= 1'b0;
            r_hs1  <= 1'b0;
            r_vs1  <= 1'b0;
        end else begin
            r_addr <= w_win ? (r_row_base + r_xsrc) : '0;
            r_rden <= w_win;
            r_hs1  <= (w_h32 < 32'(SA));
            r_vs1  <= (w_v32 < 32'(SO));
        end
    end

    assign w_win_chain = {r_win_d, r_rden};
    assign w_hs_chain  = {r_hs_d, r_hs1};
    assign w_vs_chain  = {r_vs_d, r_vs1};

    // Delay line matching the framebuffer read latency, then the output register.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_win_d   <= '0;
            r_hs_d    <= '0;
            r_vs_d    <= '0;
            r_vgad    <= '0;
            r_hsync_n <= 1'b1;
            r_vsync_n <= 1'b1;
        end else begin
            r_win_d   <= w_win_chain[RD_LAT-1:0];
            r_hs_d    <= w_hs_chain[RD_LAT-1:0];
            r_vs_d    <= w_vs_chain[RD_LAT-1:0];
            r_vgad    <= r_win_d[RD_LAT-1] ? iData : '0;
            r_hsync_n <= ~r_hs_d[RD_LAT-1];
            r_vsync_n <= ~r_vs_d[RD_LAT-1];
        end
    end

`ifdef VGA_DBUF_EN
    logic r_bank;
    logic r_addr_msb;

    // Bank latched at the start of V front porch so a frame never switches buffers mid-scan.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_bank     <= 1'b0;
            r_addr_msb <= 1'b0;
        end else begin
            if (w_h_zero && (w_v32 == 32'(SO + SP + SQ))) begin
                r_bank <= iBufSel;
            end
            r_addr_msb <= w_win & r_bank;
        end
    end

    assign oAddr = {r_addr_msb, r_addr};
`else
    assign oAddr = r_addr;
`endif

    assign oRdEn       = r_rden;
    assign VGAD        = r_vgad;
    assign oHSYNC      = r_hsync_n;
    assign oVSYNC      = r_vsync_n;
    assign oFrameStart = w_h_zero & w_v_zero & ~RESET;

endmodule
